// File: rtl/crc_ser_pkg.sv
// Shared types and helpers for the CRC word serializer.
//   SZ_*            : bus size encodings (same as data_write_n)
//   ser_state_e     : serializer state (IDLE = no current word, SHIFT = emitting)
//   word_entry_t    : one buffered word with its byte cursor
//   size_to_nbytes  : size encoding -> byte count (0 for "no write")
package crc_ser_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NB_W   = 3;
  localparam int unsigned IDX_W  = 2;

  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NB_W-1:0]   nbytes;
    logic [IDX_W-1:0]  idx;
    logic              msb_first;
  } word_entry_t;

  function automatic logic [NB_W-1:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/crc_ser_word_fifo2.sv
// Two-entry word store (CUR = word being emitted, PEND = next word).
//   clk, rst_n     : clock, synchronous active-low reset
//   clr            : synchronous flush of both entries
//   push/push_word : accept a new word (idx must already be 0)
//   advance        : non-final byte of CUR transferred, bump its cursor
//   pop            : final byte of CUR transferred; promote PEND, or load
//                    push_word directly, or empty CUR
//   cur_word       : current entry contents
//   cur_full       : CUR holds a word
//   pend_full      : PEND holds a word
module crc_ser_word_fifo2
  import crc_ser_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  word_entry_t push_word,
  input  logic        advance,
  input  logic        pop,
  output word_entry_t cur_word,
  output logic        cur_full,
  output logic        pend_full
);

  word_entry_t pend_word;

  // Push is never asserted while both entries are full, and advance/pop
  // only occur while CUR is full, so the branches below are exhaustive.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cur_word  <= '0;
      pend_word <= '0;
      cur_full  <= 1'b0;
      pend_full <= 1'b0;
    end else if (pop) begin
      if (pend_full) begin
        cur_word  <= pend_word;
        pend_full <= 1'b0;
      end else if (push) begin
        cur_word <= push_word;
      end else begin
        cur_full <= 1'b0;
      end
    end else begin
      if (advance) begin
        cur_word.idx <= IDX_W'(cur_word.idx + 2'd1);
      end
      if (push) begin
        if (!cur_full) begin
          cur_word <= push_word;
          cur_full <= 1'b1;
        end else begin
          pend_word <= push_word;
          pend_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/crc_word_serializer.sv
// Splits 8/16/32-bit bus writes into a ready/valid byte stream for the
// CRC byte FIFO, with per-word byte order and a running byte count.
//   clk, rst_n       : clock, synchronous active-low reset
//   clr              : flush buffers and zero byte_count
//   in_valid/in_size/in_data/in_msb_first : word offer (size 11 = no write)
//   in_ready         : a word can be accepted this cycle
//   out_valid/out_byte/out_ready : byte stream handshake
//   busy             : a word is being emitted
//   byte_count       : bytes transferred since reset/clr (wraps)
module crc_word_serializer
  import crc_ser_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [1:0]         in_size,
  input  logic [31:0]        in_data,
  input  logic               in_msb_first,
  output logic               in_ready,
  output logic               out_valid,
  output logic [7:0]         out_byte,
  input  logic               out_ready,
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count
);

  ser_state_e       state;
  word_entry_t      cur_word;
  word_entry_t      push_word;
  logic             cur_full;
  logic             pend_full;
  logic             accept;
  logic             xfer;
  logic             eow;
  logic [IDX_W-1:0] byte_pos;

  // Ready depends only on buffer occupancy, never on out_ready.
  assign in_ready  = !(cur_full && pend_full);
  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);

  assign accept = in_valid && in_ready && (in_size != SZ_NONE);
  assign xfer   = out_valid && out_ready;
  assign eow    = xfer && (NB_W'(cur_word.idx) == NB_W'(cur_word.nbytes - 3'd1));

  assign push_word = '{data:      in_data,
                       nbytes:    size_to_nbytes(in_size),
                       idx:       2'd0,
                       msb_first: in_msb_first};

  // MSB-first walks down from the highest valid byte of this word.
  assign byte_pos = cur_word.msb_first
                  ? IDX_W'(cur_word.nbytes - NB_W'(cur_word.idx) - 3'd1)
                  : cur_word.idx;
  assign out_byte = out_valid ? BYTE_W'(cur_word.data >> {byte_pos, 3'b000}) : 8'h00;

  crc_ser_word_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (accept),
    .push_word (push_word),
    .advance   (xfer && !eow),
    .pop       (eow),
    .cur_word  (cur_word),
    .cur_full  (cur_full),
    .pend_full (pend_full)
  );

  // State tracks CUR occupancy; a word arriving on the final byte refills CUR.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= SHIFT;
        SHIFT:   if (eow && !pend_full && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Running byte count, wraps modulo 2^COUNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      byte_count <= '0;
    end else if (xfer) begin
      byte_count <= COUNT_W'(byte_count + 1'b1);
    end
  end

endmodule

// File: tb/tb_crc_word_serializer.sv
// Directed, table-driven bench for crc_word_serializer plus hand-written
// sequences for clear, counter wrap (COUNT_W = 4) and mid-word reset.
module tb_crc_word_serializer;
  import crc_ser_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [1:0]  in_size;
  logic [31:0] in_data;
  logic        in_msb_first;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready;
  logic        busy;
  logic [15:0] byte_count;

  logic        w_clr;
  logic        w_in_valid;
  logic [1:0]  w_in_size;
  logic [31:0] w_in_data;
  logic        w_in_msb_first;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [7:0]  w_out_byte;
  logic        w_out_ready;
  logic        w_busy;
  logic [3:0]  w_byte_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  crc_word_serializer dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_size(in_size), .in_data(in_data),
    .in_msb_first(in_msb_first), .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
    .busy(busy), .byte_count(byte_count)
  );

  crc_word_serializer #(.COUNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(w_clr),
    .in_valid(w_in_valid), .in_size(w_in_size), .in_data(w_in_data),
    .in_msb_first(w_in_msb_first), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_byte(w_out_byte), .out_ready(w_out_ready),
    .busy(w_busy), .byte_count(w_byte_count)
  );

  typedef struct {
    logic        vld;
    logic [1:0]  sz;
    logic [31:0] data;
    logic        msb;
    logic        ordy;
    logic        e_ov;
    logic [7:0]  e_ob;
    logic        e_ir;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic vld, input logic [1:0] sz, input logic [31:0] data,
                              input logic msb, input logic ordy, input logic e_ov,
                              input logic [7:0] e_ob, input logic e_ir, input logic e_busy,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.vld = vld; v.sz = sz; v.data = data; v.msb = msb; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ob = e_ob; v.e_ir = e_ir; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_size = SZ_NONE; in_data = 32'h0; in_msb_first = 1'b0;
  endtask

  initial begin
    logic [1:0] wsz[5];
    int pushed;
    int seen;
    logic accepted;
    logic done;

    // Stimulus table: inputs for this cycle, outputs expected before its edge.
    vecs[0]  = mk(1, SZ_W,    32'hA1B2C3D4, 0, 1, 0, 8'h00, 1, 0, 0);
    vecs[1]  = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'hD4, 1, 1, 0);
    vecs[2]  = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'hC3, 1, 1, 1);
    vecs[3]  = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'hB2, 1, 1, 2);
    vecs[4]  = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'hA1, 1, 1, 3);
    vecs[5]  = mk(1, SZ_H,    32'hFFFF1234, 1, 1, 0, 8'h00, 1, 0, 4);
    vecs[6]  = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'h12, 1, 1, 4);
    vecs[7]  = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'h34, 1, 1, 5);
    vecs[8]  = mk(1, SZ_W,    32'h11223344, 0, 0, 0, 8'h00, 1, 0, 6);
    vecs[9]  = mk(1, SZ_W,    32'h55667788, 1, 0, 1, 8'h44, 1, 1, 6);
    vecs[10] = mk(1, SZ_B,    32'h000000AA, 0, 0, 1, 8'h44, 0, 1, 6);
    vecs[11] = mk(1, SZ_B,    32'h000000AA, 0, 0, 1, 8'h44, 0, 1, 6);
    vecs[12] = mk(1, SZ_B,    32'h000000AA, 0, 1, 1, 8'h44, 0, 1, 6);
    vecs[13] = mk(1, SZ_B,    32'h000000AA, 0, 1, 1, 8'h33, 0, 1, 7);
    vecs[14] = mk(1, SZ_B,    32'h000000AA, 0, 1, 1, 8'h22, 0, 1, 8);
    vecs[15] = mk(1, SZ_B,    32'h000000AA, 0, 1, 1, 8'h11, 0, 1, 9);
    vecs[16] = mk(1, SZ_B,    32'h000000AA, 0, 1, 1, 8'h55, 1, 1, 10);
    vecs[17] = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'h66, 0, 1, 11);
    vecs[18] = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'h77, 0, 1, 12);
    vecs[19] = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'h88, 0, 1, 13);
    vecs[20] = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'hAA, 1, 1, 14);
    vecs[21] = mk(1, SZ_B,    32'h00000001, 0, 1, 0, 8'h00, 1, 0, 15);
    vecs[22] = mk(1, SZ_B,    32'h00000002, 0, 1, 1, 8'h01, 1, 1, 15);
    vecs[23] = mk(1, SZ_B,    32'h00000003, 0, 1, 1, 8'h02, 1, 1, 16);
    vecs[24] = mk(1, SZ_B,    32'h00000004, 0, 1, 1, 8'h03, 1, 1, 17);
    vecs[25] = mk(0, SZ_NONE, 32'h0,        0, 1, 1, 8'h04, 1, 1, 18);
    vecs[26] = mk(1, SZ_NONE, 32'hDEADBEEF, 0, 1, 0, 8'h00, 1, 0, 19);
    vecs[27] = mk(0, SZ_NONE, 32'h0,        0, 1, 0, 8'h00, 1, 0, 19);

    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
    idle_inputs();
    w_clr = 1'b0; w_in_valid = 1'b0; w_in_size = SZ_NONE; w_in_data = 32'h0;
    w_in_msb_first = 1'b0; w_out_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_byte", 32'(out_byte), 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_byte_count", 32'(byte_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      in_valid = vecs[i].vld; in_size = vecs[i].sz; in_data = vecs[i].data;
      in_msb_first = vecs[i].msb; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_out_byte", i), 32'(out_byte), 32'(vecs[i].e_ob));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_byte_count", i), 32'(byte_count), 32'(vecs[i].e_cnt));
      step();
    end

    // clr mid-word; the word offered alongside clr must be dropped.
    idle_inputs(); out_ready = 1'b1;
    in_valid = 1'b1; in_size = SZ_W; in_data = 32'hCAFEBABE;
    step();
    idle_inputs();
    #1;
    check("clr_pre_byte0", 32'(out_byte), 32'hBE);
    step();
    check("clr_pre_byte1", 32'(out_byte), 32'hBA);
    check("clr_pre_count", 32'(byte_count), 32'd20);
    clr = 1'b1; in_valid = 1'b1; in_size = SZ_W; in_data = 32'h12345678;
    step();
    clr = 1'b0; idle_inputs();
    #1;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_out_byte", 32'(out_byte), 32'h0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_byte_count", 32'(byte_count), 32'd0);
    step();
    check("clr_dropped_word", 32'(out_valid), 32'd0);

    // Counter wrap: 17 bytes through a 4-bit counter.
    wsz[0] = SZ_W; wsz[1] = SZ_W; wsz[2] = SZ_W; wsz[3] = SZ_W; wsz[4] = SZ_B;
    pushed = 0; seen = 0; done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      w_in_valid = (pushed < 5);
      w_in_size  = (pushed < 5) ? wsz[pushed] : SZ_NONE;
      w_in_data  = 32'h01020304 + 32'(cyc);
      #1;
      if (w_out_valid) seen++;
      accepted = w_in_valid && w_in_ready;
      step();
      if (accepted) pushed++;
      if (pushed == 5 && !w_busy) done = 1'b1;
    end
    w_in_valid = 1'b0; w_in_size = SZ_NONE;
    check("wrap_completed", 32'(done), 32'd1);
    check("wrap_bytes_streamed", 32'(seen), 32'd17);
    check("wrap_byte_count", 32'(w_byte_count), 32'd1);

    // Reset mid-word discards the partial word.
    in_valid = 1'b1; in_size = SZ_W; in_data = 32'h0BADF00D; in_msb_first = 1'b0;
    step();
    idle_inputs();
    #1;
    check("rst_pre_byte", 32'(out_byte), 32'h0D);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_byte_count", 32'(byte_count), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
